mux4_rr_select: RTL and testbench
=================================

Name: mux4_rr_select

Overview:
- Round-robin arbiter that sits directly upstream of the 4-to-1 gate-level multiplexer.
- Arbitrates four requesting sources and drives the mux select pair (s1, s0) so the winning source's input is steered to the mux output.
- Supplies a one-hot grant and a busy flag so requesters and the consumer of the mux output know which channel is live.
- Bounds each grant with a hold counter so no source starves the others.

Parameters:
- HOLD_CYCLES, 4, maximum consecutive cycles one grant may be held (legal range 1..8).
- CNT_W, 3, width of the hold counter; must satisfy 2**CNT_W >= HOLD_CYCLES.

Ports:
- clock, input, 1, single system clock; all state updates on the rising edge.
- reset_n, input, 1, synchronous active-low reset, sampled on the rising edge of clock.
- req, input, 4, per-channel request; bit k asks for mux input ik.
- done, input, 1, current grantee finished; sampled only while busy=1.
- grant, output, 4, registered one-hot grant; all zero when idle.
- s1, output, 1, registered mux select MSB (index bit 1 of the granted channel).
- s0, output, 1, registered mux select LSB (index bit 0 of the granted channel).
- busy, output, 1, registered; 1 while a grant is active.

Behaviour:
- Reset (reset_n=0 at a clock edge): grant=0000, s1=0, s0=0, busy=0, state=IDLE, hold count=0, priority pointer ptr=0. Reset mid-grant drops the grant on that same edge, with no completion cycle.
- State IDLE:
  - If req=0000: stay IDLE; outputs unchanged (s1/s0 keep the last index).
  - Otherwise select the first set bit of req, searching ptr, ptr+1, ... modulo 4.
  - Next edge: go to GRANT; grant=onehot(k), {s1,s0}=k, busy=1, count=0.
  - Latency: req seen at edge n gives grant valid after edge n+1.
- State GRANT (winner k) is released at an edge when any of these holds:
  - done=1;
  - req[k]=0;
  - count=HOLD_CYCLES-1.
- Not released: count increments; outputs hold.
- On release:
  - ptr becomes (k+1) mod 4, so k has lowest priority next.
  - Re-arbitrate on the same edge using the current req and the new ptr.
  - If a winner exists, grant it directly with no idle bubble: count=0 and {s1,s0} update. The new winner may be k again only if k is the sole requester.
  - If no winner, go to IDLE: grant=0000, busy=0, s1/s0 hold.
- HOLD_CYCLES=1: each grant lasts exactly one cycle; with several requesters the channels rotate every cycle.
- Simultaneous done and hold-limit: a single release; no double pointer advance.
- Invariants:
  - grant is one-hot or zero.
  - {s1,s0} equals the index of the set grant bit whenever busy=1.
  - busy equals the OR of grant.
- Pointer arithmetic is 2-bit and wraps naturally (3+1 gives 0).
- Inputs are synchronous to clock; no internal synchronisers.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=1'b0, GRANT=1'b1;
  - constant NUM_CH=4;
  - function for 4-bit one-hot-to-2-bit index encode.
- One natural sub-module: rr_pick4, purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated once, shared by the IDLE and release paths.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with req=1111 -> grant=0000, s1s0=00, busy=0. Release reset -> one cycle later grant=0001, s1s0=00, busy=1.
- Single requester with done: req=0100 held, done pulsed on the 3rd grant cycle -> grant=0100, s1s0=10 for 3 cycles. req still 0100 -> regrant 0100 with no bubble. When req=0000 -> IDLE, s1s0 stays 10.
- Round-robin and hold limit: req=1111, HOLD_CYCLES=4, done=0 -> grants 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles. s1s0 follows 00, 01, 10, 11, 00.
- Request drop: req=1010 gives grant 0010; drop req[1] after 2 cycles -> next edge grant=1000, s1s0=11, count restarts at 0.
- Reset mid-grant: during grant=1000 with count=2, pulse reset_n low for one edge -> grant=0000, busy=0, ptr=0. With req=1001 afterward, the first grant is 0001.
- HOLD_CYCLES=1 build: req=0101 -> grant alternates 0001, 0100 every cycle; busy stays 1 continuously.

Source files
------------

// File: rtl/mux4_rr_select_pkg.sv
// Shared types, constants and helpers for the 4-channel round-robin mux-select arbiter.
package mux4_rr_select_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // One-hot (or zero) channel vector to its 2-bit index.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx[0] = oh[1] | oh[3];
    idx[1] = oh[2] | oh[3];
    return idx;
  endfunction

  // 2-bit index to one-hot channel vector.
  function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_select_rr_pick4.sv
// Combinational rotating-priority picker: first set req bit starting at ptr, wrapping mod 4.
module rr_pick4
  import mux4_rr_select_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  // Scan from furthest to nearest so the nearest candidate to ptr wins.
  always_comb begin
    logic [IDX_W-1:0] w_cand;
    found  = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_cand = ptr + IDX_W'(i);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_select.sv
// Round-robin arbiter driving the select pair of a 4-to-1 mux, with per-grant hold limit.
module mux4_rr_select
  import mux4_rr_select_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic [NUM_CH-1:0] grant,
  output logic              s1,
  output logic              s0,
  output logic              busy
);

  state_e            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_grant;
  logic              r_s1;
  logic              r_s0;
  logic              r_busy;

  logic [IDX_W-1:0]  w_k;
  logic              w_release;
  logic [IDX_W-1:0]  w_next_ptr;
  logic [IDX_W-1:0]  w_pick_ptr;
  logic              w_found;
  logic [IDX_W-1:0]  w_idx;

  // Release decision for the current grantee; the picker sees the advanced pointer on release.
  always_comb begin
    w_k        = onehot_to_idx(r_grant);
    w_next_ptr = w_k + IDX_W'(1);
    w_release  = 1'b0;
    if (r_state == GRANT) begin
      w_release = done | ~req[w_k] | (r_cnt == CNT_W'(HOLD_CYCLES - 1));
    end
    w_pick_ptr = w_release ? w_next_ptr : r_ptr;
  end

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_s1    <= 1'b0;
      r_s0    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_grant <= idx_to_onehot(w_idx);
            r_s1    <= w_idx[1];
            r_s0    <= w_idx[0];
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr <= w_next_ptr;
            r_cnt <= '0;
            if (w_found) begin
              // Back-to-back handover without an idle bubble.
              r_grant <= idx_to_onehot(w_idx);
              r_s1    <= w_idx[1];
              r_s0    <= w_idx[0];
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign s1    = r_s1;
  assign s0    = r_s0;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mux4_rr_select.sv
// Directed self-checking bench for mux4_rr_select (HOLD_CYCLES=4 and HOLD_CYCLES=1 instances).
module tb_mux4_rr_select;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       s1, s0, busy;

  logic [3:0] req1;
  logic       done1;
  logic [3:0] grant1;
  logic       s1_1, s0_1, busy1;

  int n_checks;
  int n_fail;

  mux4_rr_select #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .s1      (s1),
    .s0      (s0),
    .busy    (busy)
  );

  mux4_rr_select #(.HOLD_CYCLES(1), .CNT_W(3)) dut1 (
    .clock   (clk),
    .reset_n (reset_n),
    .req     (req1),
    .done    (done1),
    .grant   (grant1),
    .s1      (s1_1),
    .s0      (s0_1),
    .busy    (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed {grant, s1, s0, busy}.
  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed grant/s1s0/busy=%b_%b_%b required %b_%b_%b",
             tag, obs[6:3], obs[2:1], obs[0], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  function automatic logic [6:0] exp_busy(input logic [1:0] k);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    return {oh, k, 1'b1};
  endfunction

  initial begin
    logic [1:0] k;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    req      = 4'b1111;
    done     = 1'b0;
    req1     = 4'b0000;
    done1    = 1'b0;

    // Reset with all requesting, then first grant one cycle after release.
    tick(); tick();
    chk("reset", {grant, s1, s0, busy}, {4'b0000, 2'b00, 1'b0});
    reset_n = 1'b1;
    tick();
    chk("first_grant", {grant, s1, s0, busy}, exp_busy(2'd0));

    // Rotation with hold limit of 4 cycles per grant.
    for (int c = 1; c < 20; c++) begin
      tick();
      k = 2'(c / 4);
      chk($sformatf("rr_hold_c%0d", c), {grant, s1, s0, busy}, exp_busy(k));
    end

    // Single requester, done on 3rd grant cycle, regrant with no bubble.
    reset_n = 1'b0; req = 4'b0000;
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_no_req", {grant, s1, s0, busy}, {4'b0000, 2'b00, 1'b0});
    req = 4'b0100;
    tick();
    chk("single_c1", {grant, s1, s0, busy}, exp_busy(2'd2));
    tick();
    chk("single_c2", {grant, s1, s0, busy}, exp_busy(2'd2));
    tick();
    chk("single_c3", {grant, s1, s0, busy}, exp_busy(2'd2));
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("single_regrant", {grant, s1, s0, busy}, exp_busy(2'd2));
    req = 4'b0000;
    tick();
    chk("single_to_idle", {grant, s1, s0, busy}, {4'b0000, 2'b10, 1'b0});
    tick();
    chk("idle_hold_sel", {grant, s1, s0, busy}, {4'b0000, 2'b10, 1'b0});

    // Request drop hands over to the other requester.
    reset_n = 1'b0; req = 4'b1010;
    tick();
    reset_n = 1'b1;
    tick();
    chk("drop_c1", {grant, s1, s0, busy}, exp_busy(2'd1));
    tick();
    chk("drop_c2", {grant, s1, s0, busy}, exp_busy(2'd1));
    req = 4'b1000;
    tick();
    chk("drop_handover", {grant, s1, s0, busy}, exp_busy(2'd3));
    tick();
    chk("drop_cnt1", {grant, s1, s0, busy}, exp_busy(2'd3));
    tick();
    chk("drop_cnt2", {grant, s1, s0, busy}, exp_busy(2'd3));

    // Reset mid-grant clears pointer: req=1001 must go to channel 0 first.
    reset_n = 1'b0;
    tick();
    chk("mid_reset", {grant, s1, s0, busy}, {4'b0000, 2'b00, 1'b0});
    reset_n = 1'b1; req = 4'b1001;
    tick();
    chk("post_reset_ptr0", {grant, s1, s0, busy}, exp_busy(2'd0));

    // Done coinciding with hold limit: single release to channel 3, then back to 0.
    tick(); tick(); tick();
    chk("limit_c4", {grant, s1, s0, busy}, exp_busy(2'd0));
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_and_limit", {grant, s1, s0, busy}, exp_busy(2'd3));
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("wrap_ptr", {grant, s1, s0, busy}, exp_busy(2'd0));

    // HOLD_CYCLES=1 instance alternates every cycle with busy held.
    reset_n = 1'b0; req = 4'b0000;
    tick();
    chk("h1_reset", {grant1, s1_1, s0_1, busy1}, {4'b0000, 2'b00, 1'b0});
    reset_n = 1'b1; req1 = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      tick();
      k = (c % 2 == 0) ? 2'd0 : 2'd2;
      chk($sformatf("h1_alt_c%0d", c), {grant1, s1_1, s0_1, busy1}, exp_busy(k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
